sobel_window_engine: RTL and testbench
======================================

// Module: sobel_window_engine
// PURPOSE
//  Downstream consumer of the 3-word row shift stage. Each beat carries three vertically
//  aligned 32-bit words (top/mid/bot rows, 4 packed 8-bit pixels each).
//  Builds a 3x3 window across word boundaries and computes Sobel |gx|+|gy| per pixel.
//  Emits one packed 32-bit edge word per input word; feeds the result writer.
// PARAMETERS
//  PIX_W         8    bits per pixel
//  PIX_PER_WORD  4    pixels per word; DATA_W = PIX_W*PIX_PER_WORD = 32
//  THRESH        0    0: saturated magnitude out; >0: binary out (255 if mag>=THRESH, else 0)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       beat valid (driven from upstream write_en)
//  in_ready   out  1       engine can accept beat
//  in_last    in   1       beat is last word of the image line
//  row_top    in   32      top row word; pixel 0 (leftmost) = bits [7:0]
//  row_mid    in   32      middle row word
//  row_bot    in   32      bottom row word
//  out_valid  out  1       out_data valid
//  out_ready  in   1       downstream accepts out_data
//  out_data   out  32      4 edge pixels, same packing as inputs
// BEHAVIOUR
//  Reset (async, rst_n=0): state=EMPTY, out_valid=0, out_data=0, held word/left column=0.
//   in_ready is 1 from the first cycle after release.
//  Accept = in_valid & in_ready. Output fire = out_valid & out_ready.
//  in_ready = (state!=FLUSH) & (!out_valid | out_ready).
//  States:
//   EMPTY: no word held. Accept, !in_last -> store word as CUR, left col = replicate
//    CUR pixel0, go HOLD, no output. Accept, in_last -> emit word with left = replicate
//    pixel0 and right = replicate pixel3; stay EMPTY.
//   HOLD: accept -> emit CUR with right col = new word pixel0. Left col <= CUR pixel3.
//    CUR <= new word. !in_last: stay HOLD. in_last: go FLUSH.
//   FLUSH: in_ready=0. When output reg free, emit CUR with right = replicate pixel3.
//    Go EMPTY.
//  Emit = load out_data and set out_valid=1 on the next clk edge.
//   Latency: word k is visible 1 cycle after beat k+1 is accepted.
//   The last word of a line is visible 1 cycle after the FLUSH step.
//   An emit with concurrent fire replaces data without a bubble.
//   out_valid clears on a fire with no emit.
//  Stall: out_data and out_valid stay stable while out_valid & !out_ready.
//  Kernel per pixel, window a..i (row-major): gx=(c+2f+i)-(a+2d+g); gy=(g+2h+i)-(a+2b+c).
//   Signed 11-bit. mag = |gx|+|gy| (11-bit unsigned, max 2040).
//   THRESH=0: out = min(mag,255). Else: out = (mag>=THRESH)?255:0.
//  Lines are independent. Column state never carries across an in_last boundary.
//  Reset mid-line or mid-FLUSH discards held words; no partial output follows.
// STRUCTURE
//  sobel_pkg: PIX_W, PIX_PER_WORD, DATA_W, state enum {EMPTY,HOLD,FLUSH},
//   MAG_W=11, MAG_MAX=255.
//  Sub-module sobel_pixel_kernel: combinational, 9 pixels + THRESH -> 8-bit result.
//   Instantiated PIX_PER_WORD times in a generate loop.
//  Top holds the FSM, CUR/left-column registers and the output register.
// TESTING
//  Flat field: 1-word line, all rows 0x80808080 -> one out_data 0x00000000.
//  Vertical edge: 1-word line, all rows 0x0000FFFF -> out_data 0x00FFFF00.
//  Horizontal ramp: top=0x00000000, mid=0x20202020, bot=0x40404040, 1-word line.
//   THRESH=0 -> 0xFFFFFFFF (mag=256, saturated). THRESH=600 -> 0x00000000.
//  Multi-word line: 3 beats, in_last on beat 3.
//   Expect 3 outputs in order; in_ready=0 for exactly the FLUSH cycle.
//   A boundary edge (word1 all 0xFF, word2 all 0x00) -> byte3 of out1 = 0xFF, byte0 of out2 = 0xFF.
//  Backpressure: out_ready=0 for 5 cycles mid-line -> out_data stable, in_ready=0.
//   No beat lost or duplicated once out_ready returns high.
//  Reset asserted during FLUSH -> out_valid=0 immediately; state=EMPTY.
//   Next 1-word line produces a correct single output.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg
//   Shared constants, types and helpers for the Sobel window engine.
//   Row vectors are indexed [0]=top, [1]=mid, [2]=bot throughout.
package sobel_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 4;
  localparam int DATA_W       = PIX_W * PIX_PER_WORD;
  localparam int ROWS         = 3;
  localparam int MAG_W        = 11;   // |gx|+|gy| <= 2040
  localparam int MAG_MAX      = 255;  // saturation point of the magnitude output

  typedef enum logic [1:0] {
    EMPTY,  // no word held
    HOLD,   // one word held, waiting for its right-hand neighbour
    FLUSH   // line ended, held word still to be emitted
  } state_e;

  // One pixel column across the three rows.
  typedef logic [ROWS-1:0][PIX_W-1:0]  col_t;
  // Three vertically aligned words.
  typedef logic [ROWS-1:0][DATA_W-1:0] rows_t;

  // Extract pixel column idx (0 = leftmost) from a set of row words.
  function automatic col_t word_col(input rows_t w, input int idx);
    col_t col;
    for (int r = 0; r < ROWS; r++) begin
      col[r] = w[r][idx*PIX_W +: PIX_W];
    end
    return col;
  endfunction

endpackage

// File: rtl/sobel_pixel_kernel.sv
// sobel_pixel_kernel
//   Combinational Sobel magnitude for one pixel of a 3x3 window.
//   Window pixels a..i are row-major; the centre pixel e carries zero weight
//   in both kernels, so it is not a port.
// Ports
//   a,b,c,d,f,g,h,i  in   PIX_W  window neighbours
//   result           out  PIX_W  saturated magnitude (THRESH=0) or binary edge
module sobel_pixel_kernel
  import sobel_pkg::*;
#(
  parameter int unsigned THRESH = 0
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] d,
  input  logic [PIX_W-1:0] f,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] h,
  input  logic [PIX_W-1:0] i,
  output logic [PIX_W-1:0] result
);

  localparam logic [MAG_W-1:0] SAT = MAG_W'(MAG_MAX);

  logic [MAG_W-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [MAG_W-1:0] abs_gx, abs_gy, mag;

  // NOTE: every signal written here is assigned on every path, so no latch
  // can be inferred; a missing else/default is how latches sneak in.
  always_comb begin
    gx_pos = MAG_W'(c) + (MAG_W'(f) << 1) + MAG_W'(i);
    gx_neg = MAG_W'(a) + (MAG_W'(d) << 1) + MAG_W'(g);
    gy_pos = MAG_W'(g) + (MAG_W'(h) << 1) + MAG_W'(i);
    gy_neg = MAG_W'(a) + (MAG_W'(b) << 1) + MAG_W'(c);
    // Each partial sum is at most 1020, so subtracting the smaller from the
    // larger yields |g| directly without a signed intermediate.
    abs_gx = (gx_pos >= gx_neg) ? (gx_pos - gx_neg) : (gx_neg - gx_pos);
    abs_gy = (gy_pos >= gy_neg) ? (gy_pos - gy_neg) : (gy_neg - gy_pos);
    mag    = abs_gx + abs_gy;
    if (THRESH == 0) begin
      result = (mag > SAT) ? '1 : mag[PIX_W-1:0];
    end else begin
      result = (32'(mag) >= THRESH) ? '1 : '0;
    end
  end

endmodule

// File: rtl/sobel_window_engine.sv
// sobel_window_engine
//   Builds a 3x3 window across word boundaries from a stream of three
//   vertically aligned row words and emits one packed Sobel edge word per
//   input word. Image edges replicate the outermost pixel column; lines
//   (delimited by in_last) never share column state.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_last       input beat handshake, end of line marker
//   row_top/row_mid/row_bot  [31:0] row words, pixel 0 in bits [7:0]
//   out_valid/out_ready             output handshake
//   out_data                 [31:0] four edge pixels, same packing as input
module sobel_window_engine
  import sobel_pkg::*;
#(
  parameter int unsigned THRESH = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DATA_W-1:0] row_top,
  input  logic [DATA_W-1:0] row_mid,
  input  logic [DATA_W-1:0] row_bot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int LAST_PIX = PIX_PER_WORD - 1;
  localparam int EXT_W    = (PIX_PER_WORD + 2) * PIX_W;

  state_e state, state_nxt;
  rows_t  cur_q;     // word waiting for its right-hand neighbour
  col_t   left_q;    // column immediately left of cur_q
  rows_t  in_rows;

  logic   out_free, accept, emit;
  rows_t  win_cur;
  col_t   win_left, win_right;
  logic [ROWS-1:0][EXT_W-1:0] ext_row;
  logic [DATA_W-1:0]          edge_word;

  assign in_rows = {row_bot, row_mid, row_top};

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (accept && !in_last) state_nxt = HOLD;
      HOLD:    if (accept && in_last)  state_nxt = FLUSH;
      FLUSH:   if (out_free)           state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake and window source selection.
  always_comb begin
    out_free  = !out_valid || out_ready;
    in_ready  = (state != FLUSH) && out_free;
    accept    = in_valid && in_ready;
    emit      = 1'b0;
    win_cur   = cur_q;
    win_left  = left_q;
    win_right = word_col(cur_q, LAST_PIX);
    unique case (state)
      EMPTY: begin
        // A single-word line is emitted straight from the input, both edges
        // replicated.
        emit      = accept && in_last;
        win_cur   = in_rows;
        win_left  = word_col(in_rows, 0);
        win_right = word_col(in_rows, LAST_PIX);
      end
      HOLD: begin
        emit      = accept;
        win_right = word_col(in_rows, 0);
      end
      FLUSH:   emit = out_free;
      default: emit = 1'b0;
    endcase
  end

  // Held word and left column.
  // NOTE: these are a handful of control-relevant registers, not a memory
  // array, so resetting them is cheap and makes a mid-line reset clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      left_q <= '0;
    end else if (accept) begin
      if (state == EMPTY && !in_last) begin
        cur_q  <= in_rows;
        left_q <= word_col(in_rows, 0);
      end else if (state == HOLD) begin
        left_q <= word_col(cur_q, LAST_PIX);
        cur_q  <= in_rows;
      end
    end
  end

  // Extended rows: left column, the four word pixels, right column.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      ext_row[r] = {win_right[r], win_cur[r], win_left[r]};
    end
  end

  for (genvar p = 0; p < PIX_PER_WORD; p++) begin : g_pix
    sobel_pixel_kernel #(.THRESH(THRESH)) u_kernel (
      .a      (ext_row[0][p*PIX_W +: PIX_W]),
      .b      (ext_row[0][(p+1)*PIX_W +: PIX_W]),
      .c      (ext_row[0][(p+2)*PIX_W +: PIX_W]),
      .d      (ext_row[1][p*PIX_W +: PIX_W]),
      .f      (ext_row[1][(p+2)*PIX_W +: PIX_W]),
      .g      (ext_row[2][p*PIX_W +: PIX_W]),
      .h      (ext_row[2][(p+1)*PIX_W +: PIX_W]),
      .i      (ext_row[2][(p+2)*PIX_W +: PIX_W]),
      .result (edge_word[p*PIX_W +: PIX_W])
    );
  end

  // Output register: an emit overrides a concurrent fire so back-to-back
  // words stream without a bubble; data holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= edge_word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_window_engine.sv
module tb_sobel_window_engine;

  localparam int THR_B = 600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [31:0] row_top, row_mid, row_bot;
  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] out_data_a, out_data_b;

  always #5 clk = ~clk;

  sobel_window_engine #(.THRESH(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_last(in_last), .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
  );

  sobel_window_engine #(.THRESH(THR_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_last(in_last), .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] lt[$], lm[$], lb[$];          // current line, per row
  logic [31:0] exp_a[$], exp_b[$];           // expected outputs
  logic [31:0] got_a[$], got_b[$];           // received outputs of last line
  int          low_ready_cycles;
  int          stall_from = -1;
  int          stall_len  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: pixel of row r at line position x, clamped to the line edges.
  function automatic int px(input int r, input int x);
    int n = lt.size() * 4;
    int xc;
    logic [31:0] w;
    xc = (x < 0) ? 0 : ((x > n - 1) ? n - 1 : x);
    case (r)
      0:       w = lt[xc / 4];
      1:       w = lm[xc / 4];
      default: w = lb[xc / 4];
    endcase
    return int'(w[(xc % 4) * 8 +: 8]);
  endfunction

  function automatic logic [7:0] sobel_ref(input int x, input int thresh);
    int a, b, c, d, f, g, h, i, gx, gy, mag;
    a = px(0, x - 1); b = px(0, x); c = px(0, x + 1);
    d = px(1, x - 1);               f = px(1, x + 1);
    g = px(2, x - 1); h = px(2, x); i = px(2, x + 1);
    gx  = (c + 2 * f + i) - (a + 2 * d + g);
    gy  = (g + 2 * h + i) - (a + 2 * b + c);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (thresh == 0) return (mag > 255) ? 8'hFF : 8'(mag);
    return (mag >= thresh) ? 8'hFF : 8'h00;
  endfunction

  task automatic build_expected();
    logic [31:0] wa, wb;
    for (int k = 0; k < lt.size(); k++) begin
      for (int j = 0; j < 4; j++) begin
        wa[j*8 +: 8] = sobel_ref(4 * k + j, 0);
        wb[j*8 +: 8] = sobel_ref(4 * k + j, THR_B);
      end
      exp_a.push_back(wa);
      exp_b.push_back(wb);
    end
  endtask

  task automatic set_line1(input logic [31:0] t, input logic [31:0] m, input logic [31:0] b);
    lt.delete(); lm.delete(); lb.delete();
    lt.push_back(t); lm.push_back(m); lb.push_back(b);
  endtask

  task automatic rand_line(input int n);
    lt.delete(); lm.delete(); lb.delete();
    for (int k = 0; k < n; k++) begin
      lt.push_back($urandom()); lm.push_back($urandom()); lb.push_back($urandom());
    end
  endtask

  // Streams the current line while checking every output fire against the
  // reference. Called and returns at 1 time unit after a rising edge.
  task automatic run_line(input int rdy_pct, input int vld_pct);
    int          n = lt.size();
    int          beat = 0;
    int          cyc = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    got_a.delete(); got_b.delete();
    low_ready_cycles = 0;
    build_expected();
    while ((beat < n || exp_a.size() > 0) && cyc < 500) begin
      in_valid = (beat < n) && ($urandom_range(99) < 32'(vld_pct));
      if (in_valid) begin
        row_top = lt[beat]; row_mid = lm[beat]; row_bot = lb[beat];
      end else begin
        row_top = $urandom(); row_mid = $urandom(); row_bot = $urandom();
      end
      in_last   = in_valid && (beat == n - 1);
      out_ready = ($urandom_range(99) < 32'(rdy_pct)) &&
                  !(cyc >= stall_from && cyc < stall_from + stall_len);
      #1;
      if (prev_stall) begin
        check("stall_valid", {31'b0, out_valid_a}, 32'd1);
        check("stall_data", out_data_a, prev_data);
      end
      if (out_valid_a && !out_ready) check("stall_in_ready", {31'b0, in_ready_a}, 32'd0);
      if (!in_ready_a) low_ready_cycles++;
      if (in_valid && in_ready_a) beat++;
      if (out_valid_a && out_ready) begin
        if (exp_a.size() == 0) begin
          check("unexpected_output", {31'b0, out_valid_a}, 32'd0);
        end else begin
          check("edge_word_thr0", out_data_a, exp_a.pop_front());
          check("edge_word_thr600", out_data_b, exp_b.pop_front());
          got_a.push_back(out_data_a);
          got_b.push_back(out_data_b);
        end
      end
      prev_stall = out_valid_a && !out_ready;
      prev_data  = out_data_a;
      @(posedge clk); #1;
      cyc++;
    end
    check("line_drained", 32'(exp_a.size()), 32'd0);
    check("beats_accepted", 32'(beat), 32'(n));
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    exp_a.delete(); exp_b.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    row_top = '0; row_mid = '0; row_bot = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid_a}, 32'd0);
    check("reset_out_data", out_data_a, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", {31'b0, in_ready_a}, 32'd1);

    // Flat field
    set_line1(32'h80808080, 32'h80808080, 32'h80808080);
    run_line(100, 100);
    check("flat_field", got_a[0], 32'h00000000);

    // Vertical edge
    set_line1(32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF);
    run_line(100, 100);
    check("vertical_edge", got_a[0], 32'h00FFFF00);

    // Horizontal ramp: mag=256 saturates, and stays under a 600 threshold
    set_line1(32'h00000000, 32'h20202020, 32'h40404040);
    run_line(100, 100);
    check("ramp_thr0", got_a[0], 32'hFFFFFFFF);
    check("ramp_thr600", got_b[0], 32'h00000000);

    // Multi-word line with a word-boundary edge
    rand_line(3);
    lt[0] = '1; lm[0] = '1; lb[0] = '1;
    lt[1] = '0; lm[1] = '0; lb[1] = '0;
    run_line(100, 100);
    check("multi_count", 32'(got_a.size()), 32'd3);
    check("flush_ready_low_cycles", 32'(low_ready_cycles), 32'd1);
    check("boundary_out1_b3", {24'b0, got_a[0][31:24]}, 32'hFF);
    check("boundary_out2_b0", {24'b0, got_a[1][7:0]}, 32'hFF);

    // Backpressure: out_ready low for 5 cycles mid-line
    rand_line(6);
    stall_from = 3; stall_len = 5;
    run_line(100, 100);
    stall_from = -1; stall_len = 0;
    check("stall_count", 32'(got_a.size()), 32'd6);

    // Random lines with random handshakes
    for (int l = 0; l < 25; l++) begin
      rand_line(int'($urandom_range(1, 5)));
      run_line(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
    end

    // Reset asserted while in FLUSH
    out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b0;
    row_top = $urandom(); row_mid = $urandom(); row_bot = $urandom();
    @(posedge clk); #1;
    in_last = 1'b1;
    row_top = $urandom(); row_mid = $urandom(); row_bot = $urandom();
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("flush_in_ready", {31'b0, in_ready_a}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_flush_out_valid", {31'b0, out_valid_a}, 32'd0);
    check("rst_flush_out_data", out_data_a, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'b0, in_ready_a}, 32'd1);
    check("post_rst_no_output", {31'b0, out_valid_a}, 32'd0);
    rand_line(1);
    run_line(100, 100);
    check("post_rst_count", 32'(got_a.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
